mips_trace_buffer: RTL and testbench
====================================

// Module: mips_trace_buffer
// PURPOSE
//  Debug trace capture that consumes the processor core's per-cycle outputs (nextPC, ula_result, data_mem).
//  Armed by software/bench; triggers when nextPC equals a programmable address, then records one
//  {pc, ula, mem} sample per clock into an internal FIFO, drained by a valid/ready read port.
//  Sits directly downstream of the core top level; purely observational, never stalls the core.
// PARAMETERS
//  DEPTH       16  FIFO entries (power of two, >=2)
//  ADDR_W      4   log2(DEPTH)
//  CAPTURE_LEN 8   samples recorded per trigger, including the trigger sample (1..255)
// PORTS
//  clock        in   1   rising-edge clock, same as core
//  reset        in   1   asynchronous, active-high; clears all state
//  arm          in   1   1-cycle pulse: enter ARMED (from any state)
//  clear        in   1   1-cycle pulse: flush FIFO, zero ovf_count
//  trig_pc      in   32  trigger address compared against pc_in
//  pc_in        in   32  core nextPC
//  ula_in       in   32  core ula_result
//  mem_in       in   32  core data_mem
//  out_valid    out  1   FIFO head valid
//  out_ready    in   1   consumer accepts head
//  out_pc       out  32  head sample pc
//  out_ula      out  32  head sample ula
//  out_mem      out  32  head sample mem
//  fill         out  ADDR_W+1  entries currently stored
//  state        out  2   00 IDLE, 01 ARMED, 10 CAPTURE, 11 DONE
//  ovf_count    out  8   samples dropped because FIFO full, saturating at 255
// BEHAVIOUR
//  Reset: state=IDLE, FIFO empty, fill=0, out_valid=0, out_pc/out_ula/out_mem=0, ovf_count=0, sample counter=0.
//  FSM, evaluated at each rising edge, priority arm > normal transition:
//   IDLE    : arm -> ARMED.
//   ARMED   : pc_in==trig_pc -> push sample, cnt=1, -> CAPTURE (-> DONE if CAPTURE_LEN==1).
//   CAPTURE : push sample every cycle, cnt++; when cnt reaches CAPTURE_LEN -> DONE.
//   DONE    : hold; arm -> ARMED. Stored data untouched.
//   arm in CAPTURE aborts capture (sample of that cycle not pushed), -> ARMED, FIFO kept.
//  Sample = {pc_in, ula_in, mem_in} sampled on the same edge as the push; no added latency.
//  Counted samples include dropped ones: capture window is always exactly CAPTURE_LEN cycles.
//  FIFO: first-word-fall-through; out_valid = (fill!=0); out_* = head entry, 0 when empty.
//   Pop when out_valid && out_ready. Push when FSM requests and (fill<DEPTH or pop same cycle).
//   Full with no pop: sample dropped, ovf_count++ (saturate 255).
//   Push+pop same cycle: fill unchanged, both succeed, including at fill==DEPTH.
//   Pop when empty: ignored. out_ready may be held high continuously.
//   Pointers ADDR_W bits, wrap modulo DEPTH; fill is ADDR_W+1 bits to represent DEPTH.
//  clear: FIFO pointers and fill -> 0, ovf_count -> 0 on that edge; push/pop that cycle discarded;
//   FSM state unaffected. clear and arm together: both take effect.
//  Asynchronous reset mid-capture: immediate return to reset values, no partial entry retained.
//  out_* registered from FIFO storage via read pointer (combinational read of register array).
// TESTING
//  T1 reset: assert reset mid-CAPTURE with fill=5 -> state=00, fill=0, out_valid=0, ovf_count=0 without a clock edge.
//  T2 trigger: arm, trig_pc=0x0000000C, pc sequence 0,4,8,C,10.. -> first entry pc=0x0C, 8 entries, state=11, fill=8.
//  T3 overflow: DEPTH=16, CAPTURE_LEN=20, out_ready=0 -> fill=16, ovf_count=4, first 16 samples in order.
//  T4 full push+pop: fill=16 in CAPTURE, out_ready=1 one cycle -> fill stays 16, ovf_count unchanged, head advances.
//  T5 re-arm abort: arm at cnt=3 in CAPTURE -> state=01, fill=3; next trigger appends 8 more (fill=11).
//  T6 clear+drain: after T2 pulse clear -> fill=0, out_valid=0; repeat T2 with out_ready=1 -> 8 pops, order preserved.

Source files
------------

// File: rtl/mips_trace_buffer_if.sv
// mips_trace_buffer_if: valid/ready read port carrying one {pc, ula, mem} trace sample
interface mips_trace_buffer_if;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_ula;
  logic [31:0] out_mem;
  modport master (output out_valid, out_pc, out_ula, out_mem, input out_ready);
  modport slave  (input out_valid, out_pc, out_ula, out_mem, output out_ready);
endinterface

// File: rtl/mips_trace_buffer.sv
// mips_trace_buffer: pc-triggered capture of core outputs into a first-word-fall-through trace FIFO
module mips_trace_buffer #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int CAPTURE_LEN = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 arm,
  input  logic                 clear,
  input  logic [31:0]          trig_pc,
  input  logic [31:0]          pc_in,
  input  logic [31:0]          ula_in,
  input  logic [31:0]          mem_in,
  mips_trace_buffer_if.master  rd,
  output logic [ADDR_W:0]      fill,
  output logic [1:0]           state,
  output logic [7:0]           ovf_count
);
  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] ARMED   = 2'b01;
  localparam logic [1:0] CAPTURE = 2'b10;
  localparam logic [1:0] DONE    = 2'b11;
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [7:0] LEN = 8'(CAPTURE_LEN);
  logic [95:0]       store [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [7:0]        cnt;
  logic              req, pop, push, drop;
  logic [95:0]       head;
  // arm wins over the capture request, so an aborting arm never pushes its cycle's sample
  always_comb begin
    req  = !arm && (state == CAPTURE || (state == ARMED && pc_in == trig_pc));
    pop  = rd.out_valid && rd.out_ready;
    push = req && (fill != FULL || pop);
    drop = req && !push;
    head = rd.out_valid ? store[rd_ptr] : '0;
  end
  assign rd.out_valid = fill != '0;
  assign {rd.out_pc, rd.out_ula, rd.out_mem} = head;
  // capture FSM: every requested cycle counts toward the window, dropped or not
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (arm) begin
      state <= ARMED;
      cnt   <= '0;
    end else if (req) begin
      cnt   <= cnt + 8'd1;
      state <= (cnt + 8'd1 == LEN) ? DONE : CAPTURE;
    end
  end
  // FIFO bookkeeping; clear discards any push/pop of its cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset || clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      ovf_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fill <= fill + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
      if (drop && ovf_count != 8'hFF) ovf_count <= ovf_count + 8'd1;
    end
  end
  // sample storage; contents are only visible through fill, so it needs no reset
  always_ff @(posedge clock) begin
    if (push && !clear) store[wr_ptr] <= {pc_in, ula_in, mem_in};
  end
endmodule

// File: tb/tb_mips_trace_buffer.sv
// tb_mips_trace_buffer: directed table and sequence checks of trigger, overflow, abort, clear and reset
module tb_mips_trace_buffer;
  logic        clock = 0, reset = 1;
  logic        arm = 0, clear = 0, arm1 = 0, clear1 = 0;
  logic [31:0] trig_pc = 32'hC, pc_in = 0, ula_in = 0, mem_in = 0;
  logic [4:0]  fill0, fill1;
  logic [1:0]  state0, state1;
  logic [7:0]  ovf0, ovf1;
  int          tests = 0, fails = 0;
  mips_trace_buffer_if rd0();
  mips_trace_buffer_if rd1();
  mips_trace_buffer #(.DEPTH(16), .ADDR_W(4), .CAPTURE_LEN(8)) u0 (
    .clock(clock), .reset(reset), .arm(arm), .clear(clear), .trig_pc(trig_pc),
    .pc_in(pc_in), .ula_in(ula_in), .mem_in(mem_in), .rd(rd0),
    .fill(fill0), .state(state0), .ovf_count(ovf0));
  mips_trace_buffer #(.DEPTH(16), .ADDR_W(4), .CAPTURE_LEN(20)) u1 (
    .clock(clock), .reset(reset), .arm(arm1), .clear(clear1), .trig_pc(trig_pc),
    .pc_in(pc_in), .ula_in(ula_in), .mem_in(mem_in), .rd(rd1),
    .fill(fill1), .state(state1), .ovf_count(ovf1));
  always #5 clock = ~clock;
  typedef struct {
    logic        a;
    logic [31:0] pc;
    logic [1:0]  st;
    logic [4:0]  f;
    logic [31:0] hpc;
  } vec_t;
  vec_t tv[12];
  function automatic logic [95:0] smp(input logic [31:0] pc);
    return {pc, pc ^ 32'h5A5A0000, ~pc};
  endfunction
  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step(input logic [31:0] pc);
    pc_in  = pc;
    ula_in = pc ^ 32'h5A5A0000;
    mem_in = ~pc;
    @(posedge clock);
    #1;
    arm = 0; clear = 0; arm1 = 0; clear1 = 0;
  endtask
  initial begin
    int k;
    rd0.out_ready = 0;
    rd1.out_ready = 0;
    tv[0]  = '{1'b1, 32'h00, 2'b01, 5'd0, 32'h00};
    tv[1]  = '{1'b0, 32'h04, 2'b01, 5'd0, 32'h00};
    tv[2]  = '{1'b0, 32'h08, 2'b01, 5'd0, 32'h00};
    tv[3]  = '{1'b0, 32'h0C, 2'b10, 5'd1, 32'h0C};
    tv[4]  = '{1'b0, 32'h10, 2'b10, 5'd2, 32'h0C};
    tv[5]  = '{1'b0, 32'h14, 2'b10, 5'd3, 32'h0C};
    tv[6]  = '{1'b0, 32'h18, 2'b10, 5'd4, 32'h0C};
    tv[7]  = '{1'b0, 32'h1C, 2'b10, 5'd5, 32'h0C};
    tv[8]  = '{1'b0, 32'h20, 2'b10, 5'd6, 32'h0C};
    tv[9]  = '{1'b0, 32'h24, 2'b10, 5'd7, 32'h0C};
    tv[10] = '{1'b0, 32'h28, 2'b11, 5'd8, 32'h0C};
    tv[11] = '{1'b0, 32'h2C, 2'b11, 5'd8, 32'h0C};
    #1;
    chk("reset_vals", {state0, fill0, rd0.out_valid, ovf0, rd0.out_pc}, '0);
    #1 reset = 0;
    for (int i = 0; i < 12; i++) begin
      arm = tv[i].a;
      step(tv[i].pc);
      chk($sformatf("trig_row%0d", i), {state0, fill0, rd0.out_valid, rd0.out_pc},
          {tv[i].st, tv[i].f, tv[i].f != 5'd0, tv[i].hpc});
    end
    chk("trig_head_full", {rd0.out_pc, rd0.out_ula, rd0.out_mem}, smp(32'hC));
    clear = 1;
    step(32'h30);
    chk("clear", {state0, fill0, rd0.out_valid, ovf0}, {2'b11, 5'd0, 1'b0, 8'd0});
    rd0.out_ready = 1;
    arm = 1;
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (rd0.out_valid) begin
        chk($sformatf("drain%0d", k), {rd0.out_pc, rd0.out_ula, rd0.out_mem}, smp(32'(12 + 4 * k)));
        k++;
      end
      step(32'(4 * i));
    end
    rd0.out_ready = 0;
    chk("drain_count", {32'(k), state0, fill0}, {32'd8, 2'b11, 5'd0});
    arm = 1;
    step(32'h0);
    step(32'hC);
    step(32'h10);
    step(32'h14);
    arm = 1;
    step(32'h18);
    chk("abort", {state0, fill0}, {2'b01, 5'd3});
    step(32'hC);
    for (int i = 0; i < 7; i++) step(32'(32'h100 + 4 * i));
    chk("rearm_append", {state0, fill0, rd0.out_pc}, {2'b11, 5'd11, 32'hC});
    clear = 1;
    arm = 1;
    step(32'h0);
    chk("clear_arm", {state0, fill0}, {2'b01, 5'd0});
    for (int i = 0; i < 5; i++) step(32'(12 + 4 * i));
    chk("pre_reset", {state0, fill0}, {2'b10, 5'd5});
    #2 reset = 1;
    #1;
    chk("async_reset", {state0, fill0, rd0.out_valid, ovf0, rd0.out_pc}, '0);
    #1 reset = 0;
    arm1 = 1;
    step(32'h0);
    for (int i = 0; i < 20; i++) step(32'(12 + 4 * i));
    chk("ovf", {state1, fill1, ovf1}, {2'b11, 5'd16, 8'd4});
    rd1.out_ready = 1;
    for (int j = 0; j < 16; j++) begin
      chk($sformatf("ovf_order%0d", j), {rd1.out_pc, rd1.out_ula, rd1.out_mem}, smp(32'(12 + 4 * j)));
      step(32'h0);
    end
    rd1.out_ready = 0;
    chk("ovf_drained", {fill1, rd1.out_valid}, {5'd0, 1'b0});
    clear1 = 1;
    step(32'h0);
    chk("clear_ovf", {fill1, ovf1}, {5'd0, 8'd0});
    arm1 = 1;
    step(32'h0);
    for (int i = 0; i < 16; i++) step(32'(12 + 4 * i));
    chk("full_cap", {state1, fill1, ovf1, rd1.out_pc}, {2'b10, 5'd16, 8'd0, 32'hC});
    rd1.out_ready = 1;
    step(32'h4C);
    rd1.out_ready = 0;
    chk("full_pushpop", {state1, fill1, ovf1, rd1.out_pc}, {2'b10, 5'd16, 8'd0, 32'h10});
    step(32'h50);
    chk("full_drop", {state1, fill1, ovf1}, {2'b10, 5'd16, 8'd1});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
